// File: rtl/wifi_sim_pkg.sv
// Shared constants and types for the WiFi event generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wifi_sim_pkg;

  // Bit positions inside each channel's event nibble.
  localparam int EVT_RX  = 0;
  localparam int EVT_TX  = 1;
  localparam int EVT_BCN = 2;
  localparam int EVT_LNK = 3;
  localparam int EVT_W   = 4;

  localparam int RSSI_W = 8;

  // Galois LFSR for x^16+x^14+x^13+x^11, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One channel's event nibble, laid out {link_chg, beacon, tx, rx}.
  typedef struct packed {
    logic lnk;
    logic bcn;
    logic tx;
    logic rx;
  } evt_nib_t;

  // Signal-strength jitter step: +1 or -1, saturating at both ends.
  function automatic logic [RSSI_W-1:0] rssi_step(input logic [RSSI_W-1:0] v,
                                                  input logic up);
    logic [RSSI_W-1:0] r;
    r = v;
    if (up) begin
      if (v != '1) r = v + RSSI_W'(1);
    end else begin
      if (v != '0) r = v - RSSI_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/wifi_sim_lfsr.sv
// 16-bit Galois LFSR driving background traffic and rssi jitter.
// Latency: new state one cycle after an enabled edge; seed load wins over enable.
// Backpressure: none; en low simply holds the state.
module wifi_sim_lfsr
  import wifi_sim_pkg::*;
(
  input  logic        clk,
  input  logic        seed_ld,
  input  logic        en,
  output logic [15:0] state
);

  // Shift right, folding the outgoing bit back through the tap mask.
  always_ff @(posedge clk) begin
    if (seed_ld) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/wifi_event_sim_mc.sv
// Multi-channel WiFi event generator: forced/random/beacon pulses, rssi, W1C sticky, irq.
// Latency: inputs sampled at an edge appear on pulses/link_up/rssi/sticky after it; irq one cycle later.
// Backpressure: none; sim_en low freezes state and drops forces. Option: WIFI_SIM_RSSI_JITTER_EN.
module wifi_event_sim_mc
  import wifi_sim_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter int          BEACON_PERIOD = 6_250_000,
  parameter logic [7:0]  RSSI_DEFAULT  = 8'h50,
  localparam int         CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sim_en,
  input  logic                     traffic_en,
  input  logic [7:0]               traffic_rate,
  input  logic [NUM_CH-1:0]        force_rx,
  input  logic [NUM_CH-1:0]        force_tx,
  input  logic [NUM_CH-1:0]        force_link,
  input  logic                     rssi_wr,
  input  logic [CH_W-1:0]          rssi_ch,
  input  logic [RSSI_W-1:0]        rssi_val,
  input  logic [EVT_W*NUM_CH-1:0]  evt_clr,
  input  logic [EVT_W*NUM_CH-1:0]  irq_mask,
  output logic [NUM_CH-1:0]        rx_pulse,
  output logic [NUM_CH-1:0]        tx_pulse,
  output logic [NUM_CH-1:0]        beacon_pulse,
  output logic [NUM_CH-1:0]        link_chg,
  output logic [NUM_CH-1:0]        link_up,
  output logic [RSSI_W*NUM_CH-1:0] rssi,
  output logic [EVT_W*NUM_CH-1:0]  evt_sticky,
  output logic                     irq
);

  localparam int CNT_W    = (BEACON_PERIOD > 1) ? $clog2(BEACON_PERIOD) : 1;
  localparam int BCN_STEP = BEACON_PERIOD / NUM_CH;

  logic [CNT_W-1:0]                 bcn_cnt;
  logic [CH_W-1:0]                  rr;
  logic [15:0]                      lfsr;
  logic                             lfsr_unused;
  logic                             hit;
  logic [NUM_CH-1:0]                rx_nxt;
  logic [NUM_CH-1:0]                tx_nxt;
  logic [NUM_CH-1:0]                bcn_nxt;
  logic [NUM_CH-1:0]                lnk_nxt;
  evt_nib_t [NUM_CH-1:0]            evt_set;
  logic [NUM_CH-1:0][RSSI_W-1:0]    rssi_q;

  wifi_sim_lfsr u_lfsr (
    .clk     (clk),
    .seed_ld (rst),
    .en      (sim_en),
    .state   (lfsr)
  );

  // Upper LFSR bits are not consumed by any event decision.
  assign lfsr_unused = ^lfsr[15:9];

  assign rssi = rssi_q;

  // Next-cycle events: a force and a random hit on the same channel merge into one pulse.
  always_comb begin
    rx_nxt  = '0;
    tx_nxt  = '0;
    bcn_nxt = '0;
    lnk_nxt = '0;
    evt_set = '0;
    hit     = traffic_en && (lfsr[7:0] < traffic_rate);
    for (int i = 0; i < NUM_CH; i++) begin
      bcn_nxt[i] = sim_en && (bcn_cnt == CNT_W'(i * BCN_STEP));
      rx_nxt[i]  = sim_en && (force_rx[i] ||
                              (hit && link_up[i] && (rr == CH_W'(i))));
      tx_nxt[i]  = sim_en && (force_tx[i] ||
                              (hit && lfsr[8] && link_up[i] && (rr == CH_W'(i))));
      lnk_nxt[i] = sim_en && force_link[i];
      evt_set[i].rx  = rx_nxt[i];
      evt_set[i].tx  = tx_nxt[i];
      evt_set[i].bcn = bcn_nxt[i];
      evt_set[i].lnk = lnk_nxt[i];
    end
  end

  // Beacon counter and round-robin pointer advance only while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcn_cnt <= '0;
      rr      <= '0;
    end else if (sim_en) begin
      bcn_cnt <= (bcn_cnt == CNT_W'(BEACON_PERIOD - 1)) ? '0 : bcn_cnt + CNT_W'(1);
      rr      <= (rr == CH_W'(NUM_CH - 1)) ? '0 : rr + CH_W'(1);
    end
  end

  // Registered one-cycle pulses and link state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pulse     <= '0;
      tx_pulse     <= '0;
      beacon_pulse <= '0;
      link_chg     <= '0;
      link_up      <= '0;
    end else begin
      rx_pulse     <= rx_nxt;
      tx_pulse     <= tx_nxt;
      beacon_pulse <= bcn_nxt;
      link_chg     <= lnk_nxt;
      link_up      <= link_up ^ lnk_nxt;
    end
  end

  // Sticky status: clears apply even when disabled, a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_sticky <= '0;
    end else begin
      evt_sticky <= (evt_sticky & ~evt_clr) | evt_set;
    end
  end

  // Interrupt follows the masked sticky bits one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(evt_sticky & irq_mask);
    end
  end

  // Signal strength: host writes always land; optional beacon jitter otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) rssi_q[i] <= RSSI_DEFAULT;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rssi_wr && (rssi_ch == CH_W'(i))) begin
          rssi_q[i] <= rssi_val;
        end
`ifdef WIFI_SIM_RSSI_JITTER_EN
        else if (bcn_nxt[i]) begin
          rssi_q[i] <= rssi_step(rssi_q[i], lfsr[9]);
        end
`endif
      end
    end
  end

endmodule
